wave_frame_buf: RTL and testbench



---
 rtl/wave_frame_buf_pkg.sv | 18 +
 rtl/wave_bank_ram.sv | 27 ++
 rtl/wave_frame_buf.sv | 124 ++++++++++++
 tb/tb_wave_frame_buf.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wave_frame_buf_pkg.sv
// Shared types and defaults for the ping-pong waveform frame buffer.
// Window bounds mirror the sweep address generator.
package wave_frame_buf_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DROP_W = 8;

  localparam int WIN_LO = 701;
  localparam int WIN_HI = 1023;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_SKIP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/wave_bank_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Only the read register is reset; the array is left uninitialised.
module wave_bank_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/wave_frame_buf.sv
// Ping-pong capture buffer between the sweep generator and VGA reader.
// Completed frames swap in only at display frame boundaries.
module wave_frame_buf
  import wave_frame_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              freeze,
  input  logic              rd_frame_start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              disp_bank,
  output logic              frame_pending,
  output logic [DROP_W-1:0] drop_cnt
);

  wr_state_t         state_q, state_d;
  logic              wr_en_q;
  logic              disp_q, pend_q, sel_q;
  logic [DROP_W-1:0] drop_q;
  logic              win_start, win_end;
  logic              fill, set_pend, cnt_drop;
  logic              swap;
  logic [DATA_W-1:0] q0, q1;

  assign win_start = wr_en & ~wr_en_q;
  assign win_end   = ~wr_en & wr_en_q;
  assign swap      = rd_frame_start & pend_q;

  // wr_en_q resets high so a window already in flight at reset
  // release is not mistaken for a fresh window start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= W_IDLE;
      wr_en_q <= 1'b1;
      disp_q  <= 1'b0;
      pend_q  <= 1'b0;
      sel_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en;
      sel_q   <= disp_q;
      if (swap) disp_q <= ~disp_q;
      if (set_pend)  pend_q <= 1'b1;
      else if (swap) pend_q <= 1'b0;
      if (cnt_drop && drop_q != '1)
        drop_q <= drop_q + DROP_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    fill     = 1'b0;
    set_pend = 1'b0;
    cnt_drop = 1'b0;
    unique case (state_q)
      W_IDLE: begin
        if (win_start) begin
          if (pend_q) begin
            state_d  = W_SKIP;
            cnt_drop = 1'b1;
          end else if (freeze) begin
            state_d = W_SKIP;
          end else begin
            state_d = W_FILL;
            fill    = 1'b1;
          end
        end
      end
      W_FILL: begin
        fill = wr_en;
        if (win_end) begin
          state_d  = W_IDLE;
          set_pend = 1'b1;
        end
      end
      W_SKIP: begin
        if (win_end) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  wave_bank_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_bank0 (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (fill & disp_q),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(q0)
  );

  wave_bank_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_bank1 (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (fill & ~disp_q),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(q1)
  );

  // sel_q follows the bank that was displayed when the read was issued
  assign rd_data       = sel_q ? q1 : q0;
  assign disp_bank     = disp_q;
  assign frame_pending = pend_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_wave_frame_buf.sv
// Directed bench for wave_frame_buf with hand-computed expectations.
// A small sweep generator model drives addresses 695..1023 then 0.
module tb_wave_frame_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       freeze;
  logic       rd_frame_start;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       disp_bank;
  logic       frame_pending;
  logic [7:0] drop_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] xr = 8'h00;

  always #5 clk = ~clk;

  wave_frame_buf dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .freeze        (freeze),
    .rd_frame_start(rd_frame_start),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .disp_bank     (disp_bank),
    .frame_pending (frame_pending),
    .drop_cnt      (drop_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int a);
    logic [9:0] av;
    av      = a[9:0];
    wr_addr = av;
    wr_en   = (a >= 701);
    wr_data = av[7:0] ^ xr;
    tick();
  endtask

  task automatic sweep(input logic [7:0] x,
                       input bit rfs_end,
                       input int frz_at);
    xr = x;
    for (int a = 695; a <= 1023; a++) begin
      if (a == frz_at) freeze = 1'b1;
      cyc(a);
    end
    rd_frame_start = rfs_end;
    cyc(0);
    rd_frame_start = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_rfs();
    rd_frame_start = 1'b1;
    tick();
    rd_frame_start = 1'b0;
  endtask

  task automatic read(input int a);
    rd_addr = a[9:0];
    tick();
  endtask

  task automatic short_win();
    cyc(701);
    cyc(702);
    cyc(0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n          = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    freeze         = 1'b0;
    rd_frame_start = 1'b0;
    rd_addr        = '0;
    do_reset();

    chk("rst_rd_data", rd_data, 0);
    chk("rst_disp", disp_bank, 0);
    chk("rst_pend", frame_pending, 0);
    chk("rst_drop", drop_cnt, 0);

    // T1: one sweep, pending rises after wrap, swap shows bank 1
    xr = 8'h00;
    for (int a = 695; a <= 1023; a++) cyc(a);
    chk("t1_pend_pre", frame_pending, 0);
    cyc(0);
    chk("t1_pend_wrap", frame_pending, 1);
    pulse_rfs();
    chk("t1_disp", disp_bank, 1);
    chk("t1_pend_clr", frame_pending, 0);
    read(800);
    chk("t1_rd800", rd_data, 8'h20);

    // T2: second sweep skipped while pending
    do_reset();
    sweep(8'h00, 1'b0, -1);
    chk("t2_pend", frame_pending, 1);
    sweep(8'hFF, 1'b0, -1);
    chk("t2_drop", drop_cnt, 1);
    chk("t2_disp", disp_bank, 0);
    pulse_rfs();
    chk("t2_disp_sw", disp_bank, 1);
    read(701);
    chk("t2_rd701", rd_data, 8'hBD);

    // T3: frame start coincides with window end
    sweep(8'h0F, 1'b1, -1);
    chk("t3_disp_hold", disp_bank, 1);
    chk("t3_pend", frame_pending, 1);
    rd_addr = 10'd900;
    pulse_rfs();
    chk("t3_disp_sw", disp_bank, 0);
    chk("t3_rd_old", rd_data, 8'h84);
    tick();
    chk("t3_rd_new", rd_data, 8'h8B);

    // T4: freeze before start, then freeze raised mid-fill
    freeze = 1'b1;
    sweep(8'h33, 1'b0, -1);
    chk("t4_frz_pend", frame_pending, 0);
    chk("t4_frz_drop", drop_cnt, 1);
    freeze = 1'b0;
    sweep(8'hAA, 1'b0, 900);
    chk("t4_mid_pend", frame_pending, 1);
    freeze = 1'b0;
    pulse_rfs();
    chk("t4_disp", disp_bank, 1);
    read(950);
    chk("t4_rd950", rd_data, 8'h1C);
    read(701);
    chk("t4_rd701", rd_data, 8'h17);

    // T5: reset mid-fill at address 850
    xr = 8'h00;
    for (int a = 695; a < 850; a++) cyc(a);
    wr_addr = 10'd850;
    rst_n   = 1'b0;
    #1;
    chk("t5_rst_rd", rd_data, 0);
    chk("t5_rst_disp", disp_bank, 0);
    chk("t5_rst_pend", frame_pending, 0);
    chk("t5_rst_drop", drop_cnt, 0);
    for (int a = 850; a < 854; a++) cyc(a);
    rst_n = 1'b1;
    for (int a = 854; a <= 1023; a++) cyc(a);
    cyc(0);
    chk("t5_no_pend", frame_pending, 0);
    sweep(8'h00, 1'b0, -1);
    chk("t5_pend", frame_pending, 1);
    pulse_rfs();
    chk("t5_disp", disp_bank, 1);
    read(1000);
    chk("t5_rd1000", rd_data, 8'hE8);

    // T6: drop counter saturation
    short_win();
    chk("t6_pend", frame_pending, 1);
    for (int i = 0; i < 10; i++) short_win();
    chk("t6_drop10", drop_cnt, 10);
    for (int i = 10; i < 255; i++) short_win();
    chk("t6_drop255", drop_cnt, 255);
    for (int i = 255; i < 300; i++) short_win();
    chk("t6_sat", drop_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
